writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage_pkg.sv | 38 +++
 rtl/writeback_stage_load_align.sv | 41 ++++
 rtl/writeback_stage.sv | 106 ++++++++++
 tb/tb_writeback_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared pipeline definitions for the writeback stage: write codes, result
// source select and the W-register control struct.
package writeback_stage_pkg;

   typedef enum logic [2:0] {
      WE_NONE = 3'b000,
      WE_WORD = 3'b001,
      WE_LH   = 3'b010,
      WE_LB   = 3'b011,
      WE_LHU  = 3'b110,
      WE_LBU  = 3'b111
   } we_code_e;

   typedef enum logic [1:0] {
      SRC_ALU  = 2'b00,
      SRC_LOAD = 2'b01,
      SRC_PC4  = 2'b10,
      SRC_RSVD = 2'b11
   } result_src_e;

   // Control half of the W register; the datapath value is kept alongside it
   // because its width follows the stage parameter.
   typedef struct packed {
      logic       valid;
      logic [2:0] we_code;
      logic [4:0] rd;
      logic       misalign;
   } w_ctrl_t;

   function automatic logic is_half(input logic [2:0] code);
      return (code == WE_LH) || (code == WE_LHU);
   endfunction

   function automatic logic is_byte(input logic [2:0] code);
      return (code == WE_LB) || (code == WE_LBU);
   endfunction

endpackage

// File: rtl/writeback_stage_load_align.sv
// Load lane alignment plus optional sign/zero extension; the same logic
// serves load capture (shift only) and forwarding (extend only).
module load_align
   import writeback_stage_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [2:0]            we_code,
   input  logic [1:0]            addr,
   input  logic                  extend,
   input  logic [DATA_WIDTH-1:0] data,
   output logic [DATA_WIDTH-1:0] result
);

   logic [4:0]            shamt;
   logic [DATA_WIDTH-1:0] shifted;

   always_comb begin
      shamt = 5'd0;
      if (is_half(we_code)) begin
         shamt = {addr[1], 4'b0000};
      end else if (is_byte(we_code)) begin
         shamt = {addr, 3'b000};
      end
      shifted = data >> shamt;
   end

   always_comb begin
      result = shifted;
      if (extend) begin
         case (we_code)
            WE_LH:   result = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            WE_LHU:  result = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
            WE_LB:   result = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            WE_LBU:  result = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
            default: result = shifted;
         endcase
      end
   end

endmodule

// File: rtl/writeback_stage.sv
// Writeback pipeline register: selects the M-stage result, aligns loads,
// drives the regfile write port and forwarding, and counts retirements.
module writeback_stage
   import writeback_stage_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall_i,
   input  logic                  flush_i,
   input  logic                  valid_m_i,
   input  logic [1:0]            result_src_m_i,
   input  logic [2:0]            we_code_m_i,
   input  logic [4:0]            rd_m_i,
   input  logic [DATA_WIDTH-1:0] alu_result_m_i,
   input  logic [DATA_WIDTH-1:0] read_data_m_i,
   input  logic [DATA_WIDTH-1:0] pc_plus4_m_i,
   output logic [2:0]            WE3_o,
   output logic [4:0]            A3_o,
   output logic [DATA_WIDTH-1:0] WD3_o,
   output logic                  fwd_valid_o,
   output logic [4:0]            fwd_rd_o,
   output logic [DATA_WIDTH-1:0] fwd_data_o,
   output logic                  misalign_o,
   output logic [CNT_WIDTH-1:0]  instret_o
);

   w_ctrl_t               w_ctrl;
   w_ctrl_t               next_ctrl;
   logic [DATA_WIDTH-1:0] w_data;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [DATA_WIDTH-1:0] load_data;
   logic [CNT_WIDTH-1:0]  instret_q;
   logic                  misaligned;

   load_align #(.DATA_WIDTH(DATA_WIDTH)) u_capture_align (
      .we_code (we_code_m_i),
      .addr    (alu_result_m_i[1:0]),
      .extend  (1'b0),
      .data    (read_data_m_i),
      .result  (load_data)
   );

   // Forwarding must see exactly what the regfile stores, so extension is
   // applied to the already lane-aligned W value.
   load_align #(.DATA_WIDTH(DATA_WIDTH)) u_fwd_extend (
      .we_code (w_ctrl.we_code),
      .addr    (2'b00),
      .extend  (1'b1),
      .data    (w_data),
      .result  (fwd_data_o)
   );

   always_comb begin
      misaligned = valid_m_i && (result_src_m_i == SRC_LOAD) &&
                   ((is_half(we_code_m_i) && alu_result_m_i[0]) ||
                    ((we_code_m_i == WE_WORD) && (alu_result_m_i[1:0] != 2'b00)));

      case (result_src_m_i)
         SRC_ALU:  sel_data = alu_result_m_i;
         SRC_LOAD: sel_data = load_data;
         SRC_PC4:  sel_data = pc_plus4_m_i;
         default:  sel_data = '0;
      endcase

      // x0 is not hard-wired in the regfile, so rd=0 writes are suppressed here.
      next_ctrl.valid    = valid_m_i;
      next_ctrl.rd       = rd_m_i;
      next_ctrl.misalign = misaligned;
      next_ctrl.we_code  = (valid_m_i && (rd_m_i != 5'd0) && !misaligned) ?
                           we_code_m_i : WE_NONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_ctrl <= '0;
         w_data <= '0;
      end else if (flush_i) begin
         w_ctrl <= '0;
         w_data <= '0;
      end else if (!stall_i) begin
         w_ctrl <= next_ctrl;
         w_data <= sel_data;
      end
   end

   // An instruction retires when it leaves W, misaligned bubbles included.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instret_q <= '0;
      end else if (w_ctrl.valid && !stall_i) begin
         instret_q <= instret_q + 1'b1;
      end
   end

   assign WE3_o       = w_ctrl.we_code;
   assign A3_o        = w_ctrl.rd;
   assign WD3_o       = w_data;
   assign fwd_valid_o = (w_ctrl.we_code != WE_NONE);
   assign fwd_rd_o    = w_ctrl.rd;
   assign misalign_o  = w_ctrl.misalign;
   assign instret_o   = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: hand-computed vectors for load
// alignment, misalignment, stall/flush, x0 suppression and counter wrap.
module tb_writeback_stage;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        flush;
   logic        valid_m;
   logic [1:0]  src_m;
   logic [2:0]  we_m;
   logic [4:0]  rd_m;
   logic [31:0] alu_m;
   logic [31:0] rdata_m;
   logic [31:0] pc4_m;
   logic [2:0]  we3;
   logic [4:0]  a3;
   logic [31:0] wd3;
   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_data;
   logic        misalign;
   logic [63:0] instret;

   int n_checks = 0;
   int n_errors = 0;

   writeback_stage #(.DATA_WIDTH(32), .CNT_WIDTH(64)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall_i        (stall),
      .flush_i        (flush),
      .valid_m_i      (valid_m),
      .result_src_m_i (src_m),
      .we_code_m_i    (we_m),
      .rd_m_i         (rd_m),
      .alu_result_m_i (alu_m),
      .read_data_m_i  (rdata_m),
      .pc_plus4_m_i   (pc4_m),
      .WE3_o          (we3),
      .A3_o           (a3),
      .WD3_o          (wd3),
      .fwd_valid_o    (fwd_valid),
      .fwd_rd_o       (fwd_rd),
      .fwd_data_o     (fwd_data),
      .misalign_o     (misalign),
      .instret_o      (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] src, input logic [2:0] we,
                        input logic [4:0] rd, input logic [31:0] alu,
                        input logic [31:0] rdata, input logic [31:0] pc4);
      valid_m = v;
      src_m   = src;
      we_m    = we;
      rd_m    = rd;
      alu_m   = alu;
      rdata_m = rdata;
      pc4_m   = pc4;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_we3"}, 64'(we3), 64'h0);
      check({tag, "_a3"}, 64'(a3), 64'h0);
      check({tag, "_wd3"}, 64'(wd3), 64'h0);
      check({tag, "_fwd_valid"}, 64'(fwd_valid), 64'h0);
      check({tag, "_fwd_rd"}, 64'(fwd_rd), 64'h0);
      check({tag, "_fwd_data"}, 64'(fwd_data), 64'h0);
      check({tag, "_misalign"}, 64'(misalign), 64'h0);
      check({tag, "_instret"}, instret, 64'h0);
   endtask

   initial begin
      rst_n = 1'b0;
      stall = 1'b0;
      flush = 1'b0;
      drive(1'b0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
      tick();
      tick();
      check_all_zero("reset");
      rst_n = 1'b1;

      // lbu from byte lane 3
      drive(1'b1, 2'b01, 3'b111, 5'd5, 32'h0000_1003, 32'hAABB_CCDD, 32'h0);
      tick();
      check("lbu_we3", 64'(we3), 64'h7);
      check("lbu_a3", 64'(a3), 64'd5);
      check("lbu_wd3", 64'(wd3), 64'h0000_00AA);
      check("lbu_fwd_data", 64'(fwd_data), 64'h0000_00AA);
      check("lbu_fwd_valid", 64'(fwd_valid), 64'h1);
      check("lbu_instret", instret, 64'd0);

      // lh from upper half, negative
      drive(1'b1, 2'b01, 3'b010, 5'd6, 32'h0000_1002, 32'h8001_1234, 32'h0);
      tick();
      check("lh_we3", 64'(we3), 64'h2);
      check("lh_wd3", 64'(wd3), 64'h0000_8001);
      check("lh_fwd_data", 64'(fwd_data), 64'hFFFF_8001);
      check("lh_instret", instret, 64'd1);

      // misaligned lh
      drive(1'b1, 2'b01, 3'b010, 5'd6, 32'h0000_1001, 32'h8001_1234, 32'h0);
      tick();
      check("mis_flag", 64'(misalign), 64'h1);
      check("mis_we3", 64'(we3), 64'h0);
      check("mis_fwd_valid", 64'(fwd_valid), 64'h0);
      check("mis_instret", instret, 64'd2);

      // ALU write rd=7
      drive(1'b1, 2'b00, 3'b001, 5'd7, 32'h0000_0055, 32'h0, 32'h0);
      tick();
      check("alu_mis_clear", 64'(misalign), 64'h0);
      check("alu_we3", 64'(we3), 64'h1);
      check("alu_a3", 64'(a3), 64'd7);
      check("alu_wd3", 64'(wd3), 64'h55);
      check("alu_instret", instret, 64'd3);

      // three stalled cycles with different M inputs
      stall = 1'b1;
      drive(1'b1, 2'b00, 3'b001, 5'd9, 32'h0000_1234, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_a3", 64'(a3), 64'd7);
         check("stall_wd3", 64'(wd3), 64'h55);
         check("stall_instret", instret, 64'd3);
      end
      stall = 1'b0;
      tick();
      check("unstall_a3", 64'(a3), 64'd9);
      check("unstall_wd3", 64'(wd3), 64'h1234);
      check("unstall_instret", instret, 64'd4);

      // flush wins over stall
      flush = 1'b1;
      stall = 1'b1;
      tick();
      check("flush_we3", 64'(we3), 64'h0);
      check("flush_fwd_valid", 64'(fwd_valid), 64'h0);
      check("flush_instret", instret, 64'd4);
      flush = 1'b0;
      stall = 1'b0;

      // rd=0 word write is suppressed
      drive(1'b1, 2'b00, 3'b001, 5'd0, 32'h0000_0099, 32'h0, 32'h0);
      tick();
      check("x0_we3", 64'(we3), 64'h0);
      check("x0_fwd_valid", 64'(fwd_valid), 64'h0);
      check("x0_instret", instret, 64'd4);

      // PC+4 link
      drive(1'b1, 2'b10, 3'b001, 5'd1, 32'h0000_0777, 32'h0, 32'h0000_2004);
      tick();
      check("pc4_wd3", 64'(wd3), 64'h2004);
      check("pc4_we3", 64'(we3), 64'h1);
      check("pc4_instret", instret, 64'd5);

      // reserved source selects zero
      drive(1'b1, 2'b11, 3'b001, 5'd2, 32'h0000_0777, 32'hFFFF_FFFF, 32'h0000_2008);
      tick();
      check("rsvd_wd3", 64'(wd3), 64'h0);
      check("rsvd_instret", instret, 64'd6);

      // lhu upper half
      drive(1'b1, 2'b01, 3'b110, 5'd3, 32'h0000_2002, 32'h8001_1234, 32'h0);
      tick();
      check("lhu_wd3", 64'(wd3), 64'h0000_8001);
      check("lhu_fwd_data", 64'(fwd_data), 64'h0000_8001);

      // lb lane 1, negative byte
      drive(1'b1, 2'b01, 3'b011, 5'd4, 32'h0000_2001, 32'h1234_F678, 32'h0);
      tick();
      check("lb_wd3", 64'(wd3), 64'h0012_34F6);
      check("lb_fwd_data", 64'(fwd_data), 64'hFFFF_FFF6);
      check("lb_we3", 64'(we3), 64'h3);

      // misaligned word load
      drive(1'b1, 2'b01, 3'b001, 5'd4, 32'h0000_2002, 32'h1234_5678, 32'h0);
      tick();
      check("misw_flag", 64'(misalign), 64'h1);
      check("misw_we3", 64'(we3), 64'h0);
      check("misw_instret", instret, 64'd9);

      // counter wrap from all-ones
      flush = 1'b1;
      tick();
      tick();
      flush = 1'b0;
      drive(1'b0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
      force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      release dut.instret_q;
      check("wrap_preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
      drive(1'b1, 2'b00, 3'b001, 5'd4, 32'h0000_0011, 32'h0, 32'h0);
      tick();
      drive(1'b1, 2'b00, 3'b001, 5'd5, 32'h0000_0022, 32'h0, 32'h0);
      tick();
      check("wrap_zero", instret, 64'h0);
      drive(1'b0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
      tick();
      check("wrap_one", instret, 64'h1);

      // asynchronous reset mid-stall
      drive(1'b1, 2'b00, 3'b001, 5'd6, 32'h0000_0033, 32'h0, 32'h0);
      tick();
      check("pre_rst_a3", 64'(a3), 64'd6);
      stall = 1'b1;
      flush = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      tick();
      rst_n = 1'b1;
      stall = 1'b0;
      flush = 1'b0;
      drive(1'b1, 2'b00, 3'b001, 5'd8, 32'h0000_0044, 32'h0, 32'h0);
      tick();
      check("post_rst_a3", 64'(a3), 64'd8);
      check("post_rst_wd3", 64'(wd3), 64'h44);
      check("post_rst_instret", instret, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
